mmio_io_bridge: RTL

- Parametrised memory-mapped I/O bridge between the processor's data-memory port and dmem.
- Replaces the fixed sensor/controller/screen/score/mistake wiring with N_IN synchronised input channels and N_OUT writable output registers.
- Each input channel has a sticky change flag; a free-running cycle timer is also mapped.
- Accesses outside the MMIO window pass straight through to dmem.

---
 rtl/mmio_io_bridge.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O bridge between the CPU data port and dmem.
// Decodes a 256-word MMIO window holding synchronised input channels,
// sticky change flags, writable output registers and a free-running timer.
// All other accesses pass straight through to dmem.
module mmio_io_bridge #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       N_IN        = 2,
  parameter int unsigned       N_OUT       = 4,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(12'hF00),
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    cpu_wren,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_wren,
  input  logic [DATA_W-1:0]       mem_q,
  input  logic [N_IN*DATA_W-1:0]  in_ch,
  output logic [N_OUT*DATA_W-1:0] out_ch,
  output logic [N_IN-1:0]         chg_flags
);

  // Offset bits [7:6] select a region, bits [5:0] the channel within it.
  localparam logic [1:0] RGN_IN    = 2'd0;
  localparam logic [1:0] RGN_FLAG  = 2'd1;
  localparam logic [1:0] RGN_OUT   = 2'd2;
  localparam logic [1:0] RGN_MISC  = 2'd3;
  localparam logic [5:0] IDX_TIMER = 6'd0;

  logic              hit;
  logic [7:0]        off;
  logic [1:0]        rgn;
  logic [5:0]        idx;
  logic              wr;

  logic [DATA_W-1:0] sync_q [N_IN][SYNC_STAGES];
  logic [DATA_W-1:0] p_q    [N_IN];
  logic [N_IN-1:0]   flag_q;
  logic [N_IN-1:0]   flag_d;
  logic [DATA_W-1:0] out_q  [N_OUT];
  logic [DATA_W-1:0] out_d  [N_OUT];
  logic [DATA_W-1:0] timer_q;
  logic [DATA_W-1:0] timer_d;
  logic [DATA_W-1:0] mmio_q;
  logic [DATA_W-1:0] mmio_d;
  logic              hit_q;

  // Window decode and dmem pass-through; dmem is never written on a hit.
  assign hit       = (cpu_addr[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8]);
  assign off       = cpu_addr[7:0];
  assign rgn       = off[7:6];
  assign idx       = off[5:0];
  assign wr        = cpu_wren & hit;
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_wren  = cpu_wren & ~hit;

  // Load data comes from the registered MMIO read when the previous access hit.
  assign cpu_rdata = hit_q ? mmio_q : mem_q;
  assign chg_flags = flag_q;

  // Pack output registers onto the flat output bus.
  for (genvar j = 0; j < int'(N_OUT); j++) begin : g_out
    assign out_ch[j*DATA_W +: DATA_W] = out_q[j];
  end

  // Flag next state: a change on the synchronised value beats a W1C clear.
  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < int'(N_IN); i++) begin
      flag_d[i] = (sync_q[i][SYNC_STAGES-1] != p_q[i]) |
                  (flag_q[i] & ~(wr && (rgn == RGN_FLAG) && (idx == 6'(i)) && cpu_wdata[0]));
    end
  end

  // Output register writes.
  always_comb begin
    for (int j = 0; j < int'(N_OUT); j++) begin
      out_d[j] = out_q[j];
      if (wr && (rgn == RGN_OUT) && (idx == 6'(j))) begin
        out_d[j] = cpu_wdata;
      end
    end
  end

  // Timer: any write loads zero, otherwise count up and wrap naturally.
  always_comb begin
    timer_d = timer_q + DATA_W'(1);
    if (wr && (rgn == RGN_MISC) && (idx == IDX_TIMER)) begin
      timer_d = '0;
    end
  end

  // MMIO read mux; unmapped offsets and out-of-range indices read as zero.
  always_comb begin
    mmio_d = '0;
    case (rgn)
      RGN_IN: begin
        for (int i = 0; i < int'(N_IN); i++) begin
          if (idx == 6'(i)) mmio_d = sync_q[i][SYNC_STAGES-1];
        end
      end
      RGN_FLAG: begin
        for (int i = 0; i < int'(N_IN); i++) begin
          if (idx == 6'(i)) mmio_d = DATA_W'(flag_q[i]);
        end
      end
      RGN_OUT: begin
        for (int j = 0; j < int'(N_OUT); j++) begin
          if (idx == 6'(j)) mmio_d = out_q[j];
        end
      end
      default: begin
        if (idx == IDX_TIMER) mmio_d = timer_q;
      end
    endcase
  end

  // Input synchroniser chains plus the one-cycle delayed copy for change detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[i][k] <= '0;
        p_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_IN); i++) begin
        sync_q[i][0] <= in_ch[i*DATA_W +: DATA_W];
        for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[i][k] <= sync_q[i][k-1];
        p_q[i] <= sync_q[i][SYNC_STAGES-1];
      end
    end
  end

  // Architectural MMIO state and the one-cycle read pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_q  <= '0;
      timer_q <= '0;
      mmio_q  <= '0;
      hit_q   <= 1'b0;
      for (int j = 0; j < int'(N_OUT); j++) out_q[j] <= '0;
    end else begin
      flag_q  <= flag_d;
      timer_q <= timer_d;
      mmio_q  <= mmio_d;
      hit_q   <= hit;
      for (int j = 0; j < int'(N_OUT); j++) out_q[j] <= out_d[j];
    end
  end

endmodule
